// File: rtl/mips_run_monitor.sv
// mips_run_monitor: run sequencing, cycle timeout and result compare for the MIPS CPU.
// Optional LFSR clock-enable stall injection in RUN: define MONITOR_STALL_INJECT_EN.
module mips_run_monitor #(
  parameter int WIDTH          = 32,
  parameter int NUM_CHECKS     = 1,
  parameter int RESET_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic                        cpu_reset,
  output logic                        clk_enable,
  input  logic                        active,
  input  logic [NUM_CHECKS*WIDTH-1:0] observed,
  input  logic [NUM_CHECKS*WIDTH-1:0] expected,
  input  logic [NUM_CHECKS-1:0]       check_mask,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic                        timeout,
  output logic                        arm_error,
  output logic [NUM_CHECKS-1:0]       mismatch,
  output logic [CNT_WIDTH-1:0]        cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_ARM,
    S_RUN,
    S_CHECK,
    S_DONE
  } state_t;

  localparam int HW =
    (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST =
    HW'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TERM =
    CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                state;
  logic [HW-1:0]         hold_cnt;
  logic [NUM_CHECKS-1:0] mismatch_c;
  logic                  launch;
  logic                  arm_en;
  logic                  run_en_nxt;

  assign launch = start &&
    (state == S_IDLE || state == S_DONE);

`ifdef MONITOR_STALL_INJECT_EN
  localparam logic [15:0] SEED = 16'hACE1;

  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;

  assign lfsr_nxt = {lfsr[14:0],
    lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  // Enable for the first RUN cycle comes from the
  // current word, later ones from the advanced word.
  assign arm_en     = |lfsr[1:0];
  assign run_en_nxt = |lfsr_nxt[1:0];

  // Stall pattern generator, restarted on every launch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= SEED;
    end else if (launch) begin
      lfsr <= SEED;
    end else if (state == S_RUN) begin
      lfsr <= lfsr_nxt;
    end
  end
`else
  assign arm_en     = 1'b1;
  assign run_en_nxt = 1'b1;
`endif

  // Per-channel masked compare of CPU values.
  always_comb begin
    mismatch_c = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      mismatch_c[i] = check_mask[i] &
        (observed[i*WIDTH +: WIDTH] !=
         expected[i*WIDTH +: WIDTH]);
    end
  end

  // Run sequencer with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      hold_cnt    <= '0;
      cpu_reset   <= 1'b1;
      clk_enable  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      arm_error   <= 1'b0;
      mismatch    <= '0;
      cycle_count <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (launch) begin
            state       <= S_HOLD;
            hold_cnt    <= '0;
            cpu_reset   <= 1'b1;
            clk_enable  <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            arm_error   <= 1'b0;
            mismatch    <= '0;
            cycle_count <= '0;
          end
        end
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state     <= S_ARM;
            cpu_reset <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        S_ARM: begin
          if (active) begin
            state      <= S_RUN;
            clk_enable <= arm_en;
          end else begin
            state      <= S_DONE;
            clk_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            arm_error  <= 1'b1;
            pass       <= 1'b0;
          end
        end
        S_RUN: begin
          if (!active) begin
            state      <= S_CHECK;
            clk_enable <= 1'b0;
          end else if (clk_enable) begin
            if (cycle_count != CNT_MAX) begin
              cycle_count <= cycle_count + 1'b1;
            end
            if (cycle_count == TERM) begin
              state      <= S_DONE;
              clk_enable <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              timeout    <= 1'b1;
              pass       <= 1'b0;
            end else begin
              clk_enable <= run_en_nxt;
            end
          end else begin
            clk_enable <= run_en_nxt;
          end
        end
        S_CHECK: begin
          state    <= S_DONE;
          mismatch <= mismatch_c;
          pass     <= ~|mismatch_c;
          busy     <= 1'b0;
          done     <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
